// File: rtl/osd_udp_bitmap_buf_if.sv
// Bundle of the payload byte stream, vsync, and the OSD read port that
// connects the bitmap buffer to its neighbours. The master drives the
// stream/sync/address and observes the read data and status.
interface osd_udp_bitmap_buf_if #(
    parameter int ADDR_W = 11
);
    logic              rx_valid;
    logic              rx_sop;
    logic [7:0]        rx_data;
    logic              i_vs;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        q;
    logic              udp_rec_data_valid;
    logic              rx_err;
    logic [7:0]        frame_cnt;

    modport master (
        output rx_valid, rx_sop, rx_data, i_vs, ram_addr,
        input  q, udp_rec_data_valid, rx_err, frame_cnt
    );

    modport slave (
        input  rx_valid, rx_sop, rx_data, i_vs, ram_addr,
        output q, udp_rec_data_valid, rx_err, frame_cnt
    );
endinterface

// File: rtl/osd_udp_bitmap_buf.sv
// Double-buffered 1-bpp glyph bitmap store. A UDP payload stream fills the
// back bank; banks swap only on a vsync rising edge once a complete bitmap
// is waiting, so the overlay never displays a partially written bitmap.
module osd_udp_bitmap_buf #(
    parameter int BITMAP_BYTES   = 384,
    parameter int ADDR_W         = 11,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic               pclk,
    input  logic               rst,
    osd_udp_bitmap_buf_if.slave bus
);
    localparam int WC_W = $clog2(BITMAP_BYTES);
    localparam logic [WC_W-1:0]   LAST_ADDR = WC_W'(BITMAP_BYTES - 1);
    localparam logic [ADDR_W-1:0] BYTES_A   = ADDR_W'(BITMAP_BYTES);
    localparam logic [15:0]       TMO_MAX   = 16'(TIMEOUT_CYCLES);
    localparam logic [15:0]       TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RECV, PENDING} wr_state_t;

    wr_state_t       state_reg, state_next;
    logic [WC_W-1:0] wcnt_reg, wcnt_next;
    logic [15:0]     tmo_reg, tmo_next;
    logic            rd_bank_reg, rd_bank_next;
    logic            valid_reg, valid_next;
    logic [7:0]      frame_cnt_reg, frame_cnt_next;
    logic            rx_err_reg, rx_err_next;
    logic            vs_d0_reg, vs_d1_reg;
    logic [7:0]      q_reg;

    logic            vs_rise;
    logic            we;
    logic [WC_W-1:0] waddr;
    logic            wr_bank;

    logic [7:0] mem [0:1][0:BITMAP_BYTES-1];

    assign vs_rise = vs_d0_reg & ~vs_d1_reg;
    assign wr_bank = ~rd_bank_reg;

    // State and status registers, asynchronously cleared.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            wcnt_reg      <= '0;
            tmo_reg       <= '0;
            rd_bank_reg   <= 1'b0;
            valid_reg     <= 1'b0;
            frame_cnt_reg <= 8'd0;
            rx_err_reg    <= 1'b0;
            vs_d0_reg     <= 1'b0;
            vs_d1_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wcnt_reg      <= wcnt_next;
            tmo_reg       <= tmo_next;
            rd_bank_reg   <= rd_bank_next;
            valid_reg     <= valid_next;
            frame_cnt_reg <= frame_cnt_next;
            rx_err_reg    <= rx_err_next;
            vs_d0_reg     <= bus.i_vs;
            vs_d1_reg     <= vs_d0_reg;
        end
    end

    // Write FSM: packet assembly, abort detection and the vsync bank swap.
    always_comb begin
        state_next     = state_reg;
        wcnt_next      = wcnt_reg;
        tmo_next       = tmo_reg;
        rd_bank_next   = rd_bank_reg;
        valid_next     = valid_reg;
        frame_cnt_next = frame_cnt_reg;
        rx_err_next    = 1'b0;
        we             = 1'b0;
        waddr          = wcnt_reg;
        unique case (state_reg)
            IDLE: begin
                if (bus.rx_valid && bus.rx_sop) begin
                    we         = 1'b1;
                    waddr      = '0;
                    wcnt_next  = WC_W'(1);
                    tmo_next   = '0;
                    state_next = RECV;
                end
            end
            RECV: begin
                if (bus.rx_valid) begin
                    tmo_next = '0;
                    we       = 1'b1;
                    if (bus.rx_sop) begin
                        // A new packet cuts the current one short; restart it.
                        rx_err_next = 1'b1;
                        waddr       = '0;
                        wcnt_next   = WC_W'(1);
                    end else begin
                        waddr     = wcnt_reg;
                        wcnt_next = wcnt_reg + 1'b1;
                        if (wcnt_reg == LAST_ADDR) begin
                            state_next = PENDING;
                        end
                    end
                end else if (tmo_reg >= TMO_LAST) begin
                    tmo_next    = TMO_MAX;
                    rx_err_next = 1'b1;
                    state_next  = IDLE;
                end else begin
                    tmo_next = tmo_reg + 16'd1;
                end
            end
            PENDING: begin
                // Back bank is complete and frozen until the next vsync.
                if (bus.rx_valid && bus.rx_sop) begin
                    rx_err_next = 1'b1;
                end
                if (vs_rise) begin
                    rd_bank_next   = ~rd_bank_reg;
                    valid_next     = 1'b1;
                    frame_cnt_next = frame_cnt_reg + 8'd1;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Back-bank write port; bitmap contents survive reset.
    always_ff @(posedge pclk) begin
        if (we) begin
            mem[wr_bank][waddr] <= bus.rx_data;
        end
    end

    // Registered front-bank read; out-of-range addresses read as blank.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            q_reg <= 8'h00;
        end else if (bus.ram_addr < BYTES_A) begin
            q_reg <= mem[rd_bank_reg][bus.ram_addr[WC_W-1:0]];
        end else begin
            q_reg <= 8'h00;
        end
    end

    assign bus.q                  = q_reg;
    assign bus.udp_rec_data_valid = valid_reg;
    assign bus.rx_err             = rx_err_reg;
    assign bus.frame_cnt          = frame_cnt_reg;
endmodule

// File: tb/tb_osd_udp_bitmap_buf.sv
// Directed bench for osd_udp_bitmap_buf: full packet, tearing, short packet,
// timeout, last-byte/vsync coincidence and asynchronous reset mid-packet.
module tb_osd_udp_bitmap_buf;
    localparam int BYTES = 384;
    localparam int TMO   = 300;

    logic pclk = 1'b0;
    logic rst  = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   err_cnt = 0;
    int   err_base;

    osd_udp_bitmap_buf_if #(.ADDR_W(11)) bus ();

    osd_udp_bitmap_buf #(
        .BITMAP_BYTES  (BYTES),
        .ADDR_W        (11),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .pclk(pclk),
        .rst (rst),
        .bus (bus)
    );

    always #5 pclk = ~pclk;

    // Count rx_err pulses, sampled away from the active edge.
    always @(negedge pclk) begin
        if (bus.rx_err) err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(negedge pclk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic sop);
        bus.rx_valid = 1'b1;
        bus.rx_sop   = sop;
        bus.rx_data  = d;
        tick();
    endtask

    task automatic idle_bus();
        bus.rx_valid = 1'b0;
        bus.rx_sop   = 1'b0;
    endtask

    // Sends n bytes: either constant key, or (i mod 256) xor key.
    task automatic send_pkt(input logic [7:0] key, input int n, input logic cst);
        for (int i = 0; i < n; i++) begin
            send_byte(cst ? key : (8'(i) ^ key), i == 0);
        end
        idle_bus();
    endtask

    task automatic pulse_vs();
        bus.i_vs = 1'b1;
        tick();
        tick();
        bus.i_vs = 1'b0;
        tick();
    endtask

    task automatic rd(input logic [10:0] a, output logic [7:0] d);
        bus.ram_addr = a;
        tick();
        d = bus.q;
    endtask

    logic [7:0] d;

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_sop   = 1'b0;
        bus.rx_data  = 8'h00;
        bus.i_vs     = 1'b0;
        bus.ram_addr = '0;
        #1;
        chk("rst_q", bus.q, 8'h00);
        chk("rst_valid", bus.udp_rec_data_valid, 1'b0);
        chk("rst_err", bus.rx_err, 1'b0);
        chk("rst_frame", bus.frame_cnt, 8'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // 1: full packet of (i mod 256), then vsync
        send_pkt(8'h00, BYTES, 1'b0);
        tick();
        chk("t1_no_err", err_cnt, 0);
        chk("t1_valid_pre", bus.udp_rec_data_valid, 1'b0);
        bus.i_vs = 1'b1;
        tick();
        chk("t1_valid_1cyc", bus.udp_rec_data_valid, 1'b0);
        tick();
        chk("t1_valid_2cyc", bus.udp_rec_data_valid, 1'b1);
        chk("t1_frame", bus.frame_cnt, 8'd1);
        bus.i_vs = 1'b0;
        tick();
        rd(11'd5, d);   chk("t1_q5", d, 8'h05);
        rd(11'd383, d); chk("t1_q383", d, 8'h7F);
        rd(11'd400, d); chk("t1_q400", d, 8'h00);
        rd(11'd384, d); chk("t1_q384", d, 8'h00);

        // 2: tearing protection
        send_pkt(8'hAA, BYTES, 1'b1);
        pulse_vs();
        chk("t2_frame2", bus.frame_cnt, 8'd2);
        bus.ram_addr = 11'd10;
        tick();
        chk("t2_front_aa", bus.q, 8'hAA);
        for (int i = 0; i < BYTES; i++) begin
            send_byte(8'h55, i == 0);
            if (i % 96 == 0) chk("t2_hold", bus.q, 8'hAA);
        end
        idle_bus();
        tick();
        chk("t2_hold_end", bus.q, 8'hAA);
        bus.i_vs = 1'b1;
        tick();
        chk("t2_vs_1cyc", bus.q, 8'hAA);
        tick();
        chk("t2_vs_2cyc", bus.q, 8'hAA);
        tick();
        chk("t2_vs_3cyc", bus.q, 8'h55);
        bus.i_vs = 1'b0;
        tick();
        chk("t2_frame3", bus.frame_cnt, 8'd3);

        // 3: short packet of 100 bytes cut by a new sop
        err_base = err_cnt;
        send_pkt(8'h11, 100, 1'b0);
        send_byte(8'h3C, 1'b1);
        chk("t3_err_at_101", bus.rx_err, 1'b1);
        for (int i = 1; i < BYTES; i++) begin
            send_byte(8'(i) ^ 8'h3C, 1'b0);
        end
        idle_bus();
        tick();
        chk("t3_err_count", err_cnt - err_base, 1);
        pulse_vs();
        chk("t3_frame4", bus.frame_cnt, 8'd4);
        rd(11'd0, d);   chk("t3_q0", d, 8'h3C);
        rd(11'd99, d);  chk("t3_q99", d, 8'h5F);
        rd(11'd200, d); chk("t3_q200", d, 8'hF4);

        // 4: timeout after 50 bytes
        err_base = err_cnt;
        send_pkt(8'h77, 50, 1'b0);
        for (int i = 0; i < TMO - 1; i++) tick();
        chk("t4_err_early", bus.rx_err, 1'b0);
        tick();
        chk("t4_err_pulse", bus.rx_err, 1'b1);
        tick();
        chk("t4_err_drop", bus.rx_err, 1'b0);
        chk("t4_err_count", err_cnt - err_base, 1);
        pulse_vs();
        chk("t4_frame_same", bus.frame_cnt, 8'd4);
        rd(11'd0, d); chk("t4_front_kept", d, 8'h3C);

        // 5: last byte coincides with vs_rise
        err_base = err_cnt;
        for (int i = 0; i < BYTES - 2; i++) begin
            send_byte(8'(i) ^ 8'h5A, i == 0);
        end
        bus.i_vs = 1'b1;
        send_byte(8'd126 ^ 8'h5A, 1'b0);
        send_byte(8'd127 ^ 8'h5A, 1'b0);
        idle_bus();
        tick();
        tick();
        bus.i_vs = 1'b0;
        tick();
        chk("t5_no_swap", bus.frame_cnt, 8'd4);
        rd(11'd0, d); chk("t5_front_old", d, 8'h3C);
        send_byte(8'hEE, 1'b1);
        chk("t5_drop_err", bus.rx_err, 1'b1);
        send_byte(8'hEE, 1'b0);
        send_byte(8'hEE, 1'b0);
        idle_bus();
        tick();
        chk("t5_err_count", err_cnt - err_base, 1);
        pulse_vs();
        chk("t5_swap_next", bus.frame_cnt, 8'd5);
        rd(11'd0, d);   chk("t5_q0", d, 8'h5A);
        rd(11'd1, d);   chk("t5_q1", d, 8'h5B);
        rd(11'd383, d); chk("t5_q383", d, 8'h25);

        // 6: asynchronous reset after 200 bytes
        send_pkt(8'h99, 200, 1'b0);
        rd(11'd0, d); chk("t6_pre_q", d, 8'h5A);
        rst = 1'b1;
        #1;
        chk("t6_rst_q", bus.q, 8'h00);
        chk("t6_rst_valid", bus.udp_rec_data_valid, 1'b0);
        chk("t6_rst_frame", bus.frame_cnt, 8'd0);
        chk("t6_rst_err", bus.rx_err, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        send_pkt(8'hC3, BYTES, 1'b0);
        pulse_vs();
        chk("t6_valid", bus.udp_rec_data_valid, 1'b1);
        chk("t6_frame", bus.frame_cnt, 8'd1);
        rd(11'd0, d);   chk("t6_q0_bank1", d, 8'hC3);
        rd(11'd300, d); chk("t6_q300_bank1", d, 8'hEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
